// File: rtl/lut_pkg.sv
// Shared definitions for the key->data lookup table: FSM encoding, index-width helper, counter width.
package lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOOK  = 2'd1,
        ST_RESP  = 2'd2,
        ST_CLEAR = 2'd3
    } lut_state_e;

    localparam int CNT_W_DEF = 16;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int lut_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lut_prio_match.sv
// Combinational key compare across all table entries with lowest-index-wins selection.
module lut_prio_match #(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 7,
    parameter int DATA_LEN = 32
) (
    input  logic [KEY_LEN-1:0]         i_key,
    input  logic [NR_KEY-1:0]          i_valid,
    input  logic [NR_KEY*KEY_LEN-1:0]  i_keys,
    input  logic [NR_KEY*DATA_LEN-1:0] i_data,
    input  logic [DATA_LEN-1:0]        i_default,
    output logic [DATA_LEN-1:0]        o_data,
    output logic                       o_hit
);

    logic [NR_KEY-1:0] w_match;

    // An invalid entry never matches, even if its stale key is equal.
    for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_cmp
        assign w_match[gi] = i_valid[gi] && (i_keys[gi*KEY_LEN +: KEY_LEN] == i_key);
    end

    // Walk from the top down so the lowest matching index overrides last.
    always_comb begin
        o_data = i_default;
        o_hit  = 1'b0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_data = i_data[i*DATA_LEN +: DATA_LEN];
                o_hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lut_table_ctrl.sv
// Runtime-programmable key->data lookup table with default fallback, clear sweep and handshaked lookups.
// Optional hit/miss statistics counters are built when LUT_STATS_EN is defined.
module lut_table_ctrl
    import lut_pkg::*;
#(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 7,
    parameter int DATA_LEN = 32,
    parameter int CNT_W    = CNT_W_DEF,
    localparam int IDX_W   = lut_idx_w(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [KEY_LEN-1:0]  cfg_key,
    input  logic [DATA_LEN-1:0] cfg_data,
    input  logic                cfg_vld,
    input  logic                cfg_def_we,
    output logic                cfg_ready,
    input  logic                clr_start,
    output logic                clr_done,
    input  logic                req_valid,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_data,
    output logic                resp_hit,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    lut_state_e r_state;
    lut_state_e w_state_next;

    logic                r_valid [NR_KEY];
    logic [KEY_LEN-1:0]  r_key   [NR_KEY];
    logic [DATA_LEN-1:0] r_data  [NR_KEY];
    logic [DATA_LEN-1:0] r_def;
    logic [KEY_LEN-1:0]  r_req_key;
    logic [IDX_W-1:0]    r_clr_idx;
    logic                r_clr_done;
    logic [DATA_LEN-1:0] r_resp_data;
    logic                r_resp_hit;

    logic                       w_cfg_ready;
    logic                       w_req_ready;
    logic                       w_cfg_wr;
    logic                       w_def_wr;
    logic                       w_req_fire;
    logic                       w_resp_fire;
    logic                       w_clr_last;
    logic [NR_KEY-1:0]          w_valid_flat;
    logic [NR_KEY*KEY_LEN-1:0]  w_keys_flat;
    logic [NR_KEY*DATA_LEN-1:0] w_data_flat;
    logic [DATA_LEN-1:0]        w_match_data;
    logic                       w_match_hit;

    assign w_clr_last  = (r_clr_idx == IDX_W'(NR_KEY - 1));
    assign w_cfg_wr    = w_cfg_ready && cfg_we;
    assign w_def_wr    = w_cfg_ready && cfg_def_we;
    assign w_req_fire  = w_req_ready && req_valid;
    assign w_resp_fire = resp_valid && resp_ready;

    // Handshake readies are held low while rst is asserted so every output reads 0 in reset.
    always_comb begin
        w_state_next = r_state;
        w_cfg_ready  = 1'b0;
        w_req_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst) begin
                    if (clr_start) begin
                        w_state_next = ST_CLEAR;
                    end else begin
                        w_cfg_ready = 1'b1;
                        if (!cfg_we && !cfg_def_we) begin
                            w_req_ready = 1'b1;
                            if (req_valid) begin
                                w_state_next = ST_LOOK;
                            end
                        end
                    end
                end
            end
            ST_LOOK:  w_state_next = ST_RESP;
            ST_RESP:  if (resp_ready) w_state_next = ST_IDLE;
            ST_CLEAR: if (w_clr_last) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sweep index rests at 0 outside CLEAR so each sweep starts from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx  <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= (r_state == ST_CLEAR) && w_clr_last;
            if (r_state == ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + IDX_W'(1);
            end else begin
                r_clr_idx <= '0;
            end
        end
    end

    // Index compare against every slot means an out-of-range cfg_idx writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_KEY; i++) begin
                r_valid[i] <= 1'b0;
                r_key[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (w_cfg_wr && (cfg_idx == IDX_W'(i))) begin
                    r_valid[i] <= cfg_vld;
                    r_key[i]   <= cfg_key;
                    r_data[i]  <= cfg_data;
                end else if ((r_state == ST_CLEAR) && (r_clr_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_def <= '0;
        end else if (w_def_wr) begin
            r_def <= cfg_data;
        end
    end

    for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_flat
        assign w_valid_flat[gi]                       = r_valid[gi];
        assign w_keys_flat[gi*KEY_LEN +: KEY_LEN]     = r_key[gi];
        assign w_data_flat[gi*DATA_LEN +: DATA_LEN]   = r_data[gi];
    end

    lut_prio_match #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_match (
        .i_key     (r_req_key),
        .i_valid   (w_valid_flat),
        .i_keys    (w_keys_flat),
        .i_data    (w_data_flat),
        .i_default (r_def),
        .o_data    (w_match_data),
        .o_hit     (w_match_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_key   <= '0;
            r_resp_data <= '0;
            r_resp_hit  <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_req_key <= req_key;
            end
            if (r_state == ST_LOOK) begin
                r_resp_data <= w_match_data;
                r_resp_hit  <= w_match_hit;
            end
        end
    end

    assign cfg_ready  = w_cfg_ready;
    assign req_ready  = w_req_ready;
    assign clr_done   = r_clr_done;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_resp_data;
    assign resp_hit   = r_resp_hit;

`ifdef LUT_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_resp_fire) begin
            if (r_resp_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_resp_fire;
    assign hit_cnt       = '0;
    assign miss_cnt      = '0;
`endif

endmodule

// File: tb/tb_lut_table_ctrl.sv
// Directed self-checking bench for lut_table_ctrl: config, lookups, priority, clear sweep, backpressure, reset.
module tb_lut_table_ctrl;

    localparam int NR_KEY   = 8;
    localparam int KEY_LEN  = 7;
    localparam int DATA_LEN = 32;
    localparam int CNT_W    = 16;
    localparam int IDX_W    = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_we = 1'b0;
    logic [IDX_W-1:0]    cfg_idx = '0;
    logic [KEY_LEN-1:0]  cfg_key = '0;
    logic [DATA_LEN-1:0] cfg_data = '0;
    logic                cfg_vld = 1'b0;
    logic                cfg_def_we = 1'b0;
    logic                cfg_ready;
    logic                clr_start = 1'b0;
    logic                clr_done;
    logic                req_valid = 1'b0;
    logic [KEY_LEN-1:0]  req_key = '0;
    logic                req_ready;
    logic                resp_valid;
    logic                resp_ready = 1'b0;
    logic [DATA_LEN-1:0] resp_data;
    logic                resp_hit;
    logic [CNT_W-1:0]    hit_cnt;
    logic [CNT_W-1:0]    miss_cnt;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    always #5 clk = ~clk;

    lut_table_ctrl #(
        .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key), .cfg_data(cfg_data),
        .cfg_vld(cfg_vld), .cfg_def_we(cfg_def_we), .cfg_ready(cfg_ready),
        .clr_start(clr_start), .clr_done(clr_done),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_hit(resp_hit),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [KEY_LEN-1:0] key,
                             input logic [DATA_LEN-1:0] data, input logic vld);
        cfg_we = 1'b1; cfg_idx = idx; cfg_key = key; cfg_data = data; cfg_vld = vld;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL cfg_ready: got %b expected 1", cfg_ready);
        end
        tick();
        cfg_we = 1'b0; cfg_vld = 1'b0;
        $display("cfg idx=%0d key=%h data=%h vld=%b", idx, key, data, vld);
    endtask

    task automatic cfg_default(input logic [DATA_LEN-1:0] data);
        cfg_def_we = 1'b1; cfg_data = data;
        tick();
        cfg_def_we = 1'b0;
        $display("cfg default=%h", data);
    endtask

    task automatic lookup(input logic [KEY_LEN-1:0] key, input logic [DATA_LEN-1:0] exp_data,
                          input logic exp_hit, input string name);
        req_valid = 1'b1; req_key = key;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s req_ready: got %b expected 1", name, req_ready);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL %s early resp_valid: got %b expected 0", name, resp_valid);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_hit !== exp_hit) begin
            errors++;
            $display("FAIL %s resp: got v=%b data=%h hit=%b expected v=1 data=%h hit=%b",
                     name, resp_valid, resp_data, resp_hit, exp_data, exp_hit);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        if (exp_hit) exp_hits++; else exp_misses++;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL %s resp_valid after consume: got %b expected 0", name, resp_valid);
        end
        $display("lookup %s key=%h data=%h hit=%b", name, key, resp_data, resp_hit);
    endtask

    task automatic check_stats(input string name);
        checks++;
`ifdef LUT_STATS_EN
        if (hit_cnt !== CNT_W'(exp_hits) || miss_cnt !== CNT_W'(exp_misses)) begin
            errors++;
            $display("FAIL %s stats: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     name, hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
`else
        if (hit_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL %s stats: got hit=%0d miss=%0d expected 0/0", name, hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (cfg_ready !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_in_rst: got cfg=%b req=%b expected 0/0", cfg_ready, req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || clr_done !== 1'b0 || resp_data !== '0 || resp_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b done=%b data=%h hit=%b expected all 0",
                     resp_valid, clr_done, resp_data, resp_hit);
        end
        checks++;
        if (cfg_ready !== 1'b1 || req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_idle_ready: got cfg=%b req=%b expected 1/1", cfg_ready, req_ready);
        end
        exp_hits = 0; exp_misses = 0;
        check_stats("reset");
        lookup(7'h13, 32'h0, 1'b0, "empty_table");
    endtask

    task automatic test_basic_hit();
        cfg_write(3'd3, 7'h13, 32'hDEAD_BEEF, 1'b1);
        lookup(7'h13, 32'hDEAD_BEEF, 1'b1, "basic_hit");
        check_stats("basic_hit");
    endtask

    task automatic test_default();
        // Entry and default written in the same cycle.
        cfg_def_we = 1'b1;
        cfg_write(3'd0, 7'h55, 32'h0000_5555, 1'b1);
        cfg_def_we = 1'b0;
        lookup(7'h55, 32'h0000_5555, 1'b1, "both_we_entry");
        lookup(7'h7F, 32'h0000_5555, 1'b0, "both_we_default");
        cfg_default(32'h0000_1234);
        lookup(7'h7F, 32'h0000_1234, 1'b0, "default_miss");
        check_stats("default");
    endtask

    task automatic test_cfg_priority();
        cfg_we = 1'b1; cfg_idx = 3'd6; cfg_key = 7'h66; cfg_data = 32'h6666; cfg_vld = 1'b1;
        req_valid = 1'b1; req_key = 7'h13;
        #1;
        checks++;
        if (cfg_ready !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL cfg_over_req ready: got cfg=%b req=%b expected 1/0", cfg_ready, req_ready);
        end
        tick();
        cfg_we = 1'b0; req_valid = 1'b0;
        tick(); tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL cfg_over_req lookup_dropped: got resp_valid=%b expected 0", resp_valid);
        end
        $display("cfg_priority cfg taken, request dropped");
        lookup(7'h66, 32'h6666, 1'b1, "cfg_over_req_written");
    endtask

    task automatic test_duplicate();
        cfg_write(3'd1, 7'h20, 32'hA, 1'b1);
        cfg_write(3'd5, 7'h20, 32'hB, 1'b1);
        lookup(7'h20, 32'hA, 1'b1, "dup_lowest");
        cfg_write(3'd1, 7'h20, 32'hA, 1'b0);
        lookup(7'h20, 32'hB, 1'b1, "dup_after_inval");
        cfg_write(3'd5, 7'h20, 32'hB, 1'b0);
        lookup(7'h20, 32'h1234, 1'b0, "invalid_equal_key");
        cfg_write(3'd5, 7'h20, 32'hB, 1'b1);
    endtask

    task automatic test_clear();
        int n;
        clr_start = 1'b1;
        cfg_def_we = 1'b1; cfg_data = 32'h9999;
        req_valid = 1'b1; req_key = 7'h13;
        #1;
        checks++;
        if (cfg_ready !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL clr_priority ready: got cfg=%b req=%b expected 0/0", cfg_ready, req_ready);
        end
        tick();
        clr_start = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL clr_busy ready: got cfg=%b req=%b expected 0/0", cfg_ready, req_ready);
        end
        cfg_def_we = 1'b0;
        n = 0;
        while (clr_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != NR_KEY) begin
            errors++; $display("FAIL clr_done_latency: got %0d cycles expected %0d", n, NR_KEY);
        end
        tick();
        checks++;
        if (clr_done !== 1'b0) begin
            errors++; $display("FAIL clr_done_pulse: got %b expected 0", clr_done);
        end
        $display("clear sweep done after %0d cycles", n);
        lookup(7'h13, 32'h1234, 1'b0, "after_clear_13");
        lookup(7'h20, 32'h1234, 1'b0, "after_clear_20");
        check_stats("clear");
    endtask

    task automatic test_backpressure();
        cfg_write(3'd3, 7'h13, 32'hCAFE_F00D, 1'b1);
        req_valid = 1'b1; req_key = 7'h13;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 32'hCAFE_F00D || resp_hit !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got v=%b data=%h hit=%b req_ready=%b expected 1/cafef00d/1/0",
                         i, resp_valid, resp_data, resp_hit, req_ready);
            end
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        exp_hits++;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release: got v=%b req_ready=%b expected 0/1", resp_valid, req_ready);
        end
        $display("backpressure held 5 cycles, released");
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_key = 7'h13;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b accept0: got req_ready=%b expected 1", req_ready);
        end
        tick();
        req_key = 7'h7F;
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hCAFE_F00D || resp_hit !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b resp0: got v=%b data=%h hit=%b req_ready=%b", resp_valid, resp_data, resp_hit, req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b accept1: got req_ready=%b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h1234 || resp_hit !== 1'b0) begin
            errors++; $display("FAIL b2b resp1: got v=%b data=%h hit=%b expected 1/1234/0", resp_valid, resp_data, resp_hit);
        end
        tick();
        resp_ready = 1'b0;
        exp_hits++; exp_misses++;
        $display("back_to_back two lookups served");
        check_stats("back_to_back");
    endtask

    task automatic test_rst_mid();
        req_valid = 1'b1; req_key = 7'h13;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_look: got v=%b req_ready=%b expected 0/1", resp_valid, req_ready);
        end
        exp_hits = 0; exp_misses = 0;
        check_stats("rst_in_look");
        tick(); tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_look_dropped: got resp_valid=%b expected 0", resp_valid);
        end
        lookup(7'h13, 32'h0, 1'b0, "after_rst_look");
        cfg_write(3'd2, 7'h33, 32'h3333, 1'b1);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b1 || resp_valid !== 1'b0 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_clear: got cfg_ready=%b v=%b done=%b expected 1/0/0", cfg_ready, resp_valid, clr_done);
        end
        exp_hits = 0; exp_misses = 0;
        check_stats("rst_in_clear");
        lookup(7'h33, 32'h0, 1'b0, "after_rst_clear");
        $display("reset mid-operation recovered");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_hit();
        test_default();
        test_cfg_priority();
        test_duplicate();
        test_clear();
        test_backpressure();
        test_back_to_back();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
